down_counter_preset: RTL

- Synchronous presettable down counter. It is the count-down counterpart of the team's 4-bit up counter.
- Used as a programmable divider and interval timer: load a value N, count down to zero, then either halt (one-shot) or reload (auto-reload, divide by N+1).
- Provides lookahead borrow-out so stages cascade into wider counters, and a registered terminal-count pulse for downstream control logic.

---
 rtl/down_counter_preset_pkg.sv | 13 +
 rtl/down_counter_preset_if.sv | 28 ++
 rtl/down_counter_preset.sv | 75 +++++++
 3 files changed

// File: rtl/down_counter_preset_pkg.sv
// Shared encodings for the presettable down counter: FSM states and reload modes.
package down_counter_preset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/down_counter_preset_if.sv
// Control/status bundle of the down counter; master drives controls, slave is the counter.
interface down_counter_preset_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] d_in;
  logic             load;
  logic             en_p;
  logic             en_t;
  logic             mode;
  logic             oe;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_out;
  logic             bo;
  logic             tc_pulse;
  logic             busy;

  modport master (
    output d_in, load, en_p, en_t, mode, oe,
    input  q, q_out, bo, tc_pulse, busy
  );

  modport slave (
    input  d_in, load, en_p, en_t, mode, oe,
    output q, q_out, bo, tc_pulse, busy
  );

endinterface

// File: rtl/down_counter_preset.sv
// Presettable down counter with one-shot / auto-reload modes, lookahead borrow-out
// for cascading, and a registered terminal-count pulse.
module down_counter_preset
  import down_counter_preset_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  down_counter_preset_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;
  logic             count_en;
  logic             at_zero;

  assign count_en = bus.en_p & bus.en_t;
  assign at_zero  = (q_reg == '0);

  // Load wins over counting in every state; terminal event is the enabled edge seen at q==0.
  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (bus.load) begin
      q_next      = bus.d_in;
      reload_next = bus.d_in;
      state_next  = ST_COUNT;
    end else if (state_reg == ST_COUNT && count_en) begin
      if (!at_zero) begin
        q_next = q_reg - ONE;
      end else begin
        tc_next = 1'b1;
        if (bus.mode == MODE_RELOAD) begin
          q_next = reload_reg;
        end else begin
          state_next = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      q_reg      <= '0;
      reload_reg <= '0;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      reload_reg <= reload_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= tc_next;
    end
  end

  assign bus.q        = q_reg;
  assign bus.q_out    = bus.oe ? q_reg : '0;
  assign bus.bo       = bus.en_t & at_zero & (state_reg == ST_COUNT);
  assign bus.busy     = (state_reg == ST_COUNT);
  assign bus.tc_pulse = tc_reg;

endmodule
